// File: rtl/reg_file_flags_if.sv
// Bus bundle between the instruction controller / ALU and the register file:
// write port, two read ports and the status-flag capture signals.
interface reg_file_flags_if #(
    parameter int D = 3,
    parameter int W = 8
);
    logic         wr_en;
    logic [D-1:0] wr_addr;
    logic [W-1:0] dat_in;
    logic [D-1:0] rd_addrA;
    logic [D-1:0] rd_addrB;
    logic [W-1:0] datA_out;
    logic [W-1:0] datB_out;
    logic         flag_we;
    logic         sc_in;
    logic         pari_in;
    logic         zero_in;
    logic         sc_clr;
    logic         sc_o;
    logic         pari_o;
    logic         zero_o;

    modport master (
        output wr_en, wr_addr, dat_in, rd_addrA, rd_addrB,
        output flag_we, sc_in, pari_in, zero_in, sc_clr,
        input  datA_out, datB_out, sc_o, pari_o, zero_o
    );

    modport slave (
        input  wr_en, wr_addr, dat_in, rd_addrA, rd_addrB,
        input  flag_we, sc_in, pari_in, zero_in, sc_clr,
        output datA_out, datB_out, sc_o, pari_o, zero_o
    );
endinterface

// File: rtl/reg_file_flags.sv
// Architectural register file (2 combinational reads, 1 synchronous write)
// plus the carry/parity/zero flag register fed back to the ALU.
module reg_file_flags #(
    parameter int D = 3,
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              reset,
    reg_file_flags_if.slave   bus
);
    localparam int DEPTH = 2 ** D;

    logic [W-1:0] r_regs [DEPTH];
    logic         r_sc;
    logic         r_pari;
    logic         r_zero;

    // Every register must clear asynchronously, so this stays a flop array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.wr_en) begin
            r_regs[bus.wr_addr] <= bus.dat_in;
        end
    end

    // No write bypass: reads see the pre-edge contents.
    assign bus.datA_out = r_regs[bus.rd_addrA];
    assign bus.datB_out = r_regs[bus.rd_addrB];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sc   <= 1'b0;
            r_pari <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            // Clearing the carry outranks capturing it; parity/zero are unaffected.
            if (bus.sc_clr) begin
                r_sc <= 1'b0;
            end else if (bus.flag_we) begin
                r_sc <= bus.sc_in;
            end
            if (bus.flag_we) begin
                r_pari <= bus.pari_in;
                r_zero <= bus.zero_in;
            end
        end
    end

    assign bus.sc_o   = r_sc;
    assign bus.pari_o = r_pari;
    assign bus.zero_o = r_zero;
endmodule

// File: doc/reg_file_flags.md
Name: reg_file_flags

Overview:
- Architectural register file plus status-flag register that sits directly upstream of the ALU.
- Two combinational read ports drive the ALU operands inA/inB.
- One synchronous write port accepts the ALU result (rslt) at writeback.
- Flag register latches the ALU's shift-carry, parity and zero outputs. The latched carry feeds back to the ALU's sc_i on later instructions; the latched parity feeds pari_in.

Parameters:
- D, 3, register address width; depth = 2**D registers.
- W, 8, data width; matches the ALU data path.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- wr_en  input  1  write enable for dat_in into register wr_addr
- wr_addr  input  D  write address
- dat_in  input  W  write data (ALU rslt or load data)
- rd_addrA  input  D  read address, port A
- rd_addrB  input  D  read address, port B
- datA_out  output  W  register[rd_addrA] -> ALU inA
- datB_out  output  W  register[rd_addrB] -> ALU inB
- flag_we  input  1  capture sc_in/pari_in/zero_in into the flag register
- sc_in  input  1  ALU shift/carry out
- pari_in  input  1  ALU parity out
- zero_in  input  1  ALU zero out
- sc_clr  input  1  synchronous clear of the carry flag only
- sc_o  output  1  latched carry -> ALU sc_i
- pari_o  output  1  latched parity -> ALU pari_in
- zero_o  output  1  latched zero flag (to branch logic)

Behaviour:
- Reset
  - Asynchronous: reset high clears all 2**D registers and all three flags to 0 immediately, without waiting for a clock edge.
  - Consequence: datA_out, datB_out, sc_o, pari_o and zero_o read 0 while reset is asserted.
  - Reset asserted mid-cycle overrides any pending write or flag capture.
  - Writes and flag captures resume on the first rising edge after reset deasserts.
- Reads
  - Purely combinational, zero latency; datA_out/datB_out follow the address changes within the same cycle.
  - Both ports may address the same register; both return the identical value.
- Writes
  - On rising edge with wr_en=1: reg[wr_addr] <= dat_in.
  - wr_en=0: no register changes.
  - No register is hardwired; address 0 is writable.
  - No write-through bypass: a read of wr_addr in the write cycle returns the old value; the new value is visible after the edge.
- Flags
  - On rising edge with flag_we=1: sc <= sc_in, pari <= pari_in, zero <= zero_in.
  - flag_we=0: all flags hold.
  - sc_clr=1: sc <= 0 at the edge.
  - Priority: sc_clr beats flag_we for sc only. With both high, sc <= 0 while pari and zero still capture.
  - Flag capture is independent of wr_en; any combination of the two in a cycle is legal.
- Widths
  - wr_addr/rd_addr are exactly D bits, so every address is in range.
  - dat_in is stored unmodified; no sign or zero extension.
- Not included: pipelining, stalls and handshakes; the instruction controller sequences the enables.

Test Plan:
- Reset: write 0xAB to reg 5, flag_we with sc_in=1; assert reset asynchronously between edges -> datA_out (rd_addrA=5)=0x00 and sc_o=0 before the next edge.
- Write/read: write 0x3C to reg 2, then 0xF0 to reg 7; set rd_addrA=2, rd_addrB=7 -> datA_out=0x3C, datB_out=0xF0; both ports at 7 -> both read 0xF0.
- No bypass: reg 4=0x11, write 0x22 to reg 4 with rd_addrA=4 -> 0x11 during the write cycle, 0x22 after the edge.
- wr_en=0: dat_in=0xFF, wr_addr=3, wr_en=0 across 5 edges -> reg 3 unchanged (0x00 after reset).
- Flag priority: flag_we=1, sc_in=1, pari_in=1, zero_in=1, sc_clr=1 -> sc_o=0, pari_o=1, zero_o=1; next cycle flag_we=0 with inputs toggled -> all flags hold.
- Carry chain: register 0xFF+0x01 with the ALU in the loop; flag_we captures sc_in=1 -> sc_o=1 presented to ALU sc_i for the following add.
